// File: rtl/pc060ha_mailbox_ctrl.sv
// PC060HA-style main<->sound CPU mailbox controller.
// Holds two 4-entry nibble mailboxes (M2S, S2M), their full flags, the per-side index
// registers, slave NMI gating and the slave reset latch.
// Optional feature: define PC060HA_MIRQ_EN to add the MIRQ output. The enable is written
// through master index 5.
module pc060ha_mailbox_ctrl #(
    parameter int unsigned NIB_W       = 4,
    parameter bit          SRESET_INIT = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MWR,
    input  logic             MRD,
    input  logic             MA0,
    input  logic [NIB_W-1:0] MDI,
    output logic [NIB_W-1:0] MDO,
    input  logic             SWR,
    input  logic             SRD,
    input  logic [1:0]       SA,
    input  logic [NIB_W-1:0] SDI,
    output logic [NIB_W-1:0] SDO,
    output logic             SNMI,
    output logic             SRESET
`ifdef PC060HA_MIRQ_EN
    ,
    output logic             MIRQ
`endif
);

    logic [NIB_W-1:0] m2s_q [4];
    logic [NIB_W-1:0] m2s_d [4];
    logic [NIB_W-1:0] s2m_q [4];
    logic [NIB_W-1:0] s2m_d [4];
    logic [2:0]       midx_q, midx_d;
    logic [1:0]       sidx_q, sidx_d;
    logic             m2s_full_q, m2s_full_d;
    logic             s2m_full_q, s2m_full_d;
    logic             nmi_en_q, nmi_en_d;
    logic             snmi_q, snmi_d;
    logic             sreset_q, sreset_d;
    logic [NIB_W-1:0] mdo_q, mdo_d;
    logic [NIB_W-1:0] sdo_q, sdo_d;
    logic             m2s_set, m2s_clr, s2m_set, s2m_clr;
    logic             m_rd, s_rd;
`ifdef PC060HA_MIRQ_EN
    logic             mirq_en_q, mirq_en_d;
    logic             mirq_q, mirq_d;
`endif

    // Next-state for both bus sides, flag set/clear arbitration and registered IRQ levels.
    always_comb begin
        m2s_d      = m2s_q;
        s2m_d      = s2m_q;
        midx_d     = midx_q;
        sidx_d     = sidx_q;
        nmi_en_d   = nmi_en_q;
        sreset_d   = sreset_q;
        mdo_d      = mdo_q;
        sdo_d      = sdo_q;
        m2s_set    = 1'b0;
        m2s_clr    = 1'b0;
        s2m_set    = 1'b0;
        s2m_clr    = 1'b0;
`ifdef PC060HA_MIRQ_EN
        mirq_en_d  = mirq_en_q;
        mirq_d     = s2m_full_q & mirq_en_q;
`endif
        // A write strobe in the same cycle suppresses the read entirely.
        m_rd       = MRD & ~MWR;
        s_rd       = SRD & ~SWR;
        snmi_d     = m2s_full_q & nmi_en_q;

        // Master side
        if (MWR) begin
            if (!MA0) begin
                midx_d = MDI[2:0];
            end else if (!midx_q[2]) begin
                m2s_d[midx_q[1:0]] = MDI;
                m2s_set            = (midx_q[1:0] == 2'd3);
                midx_d             = {1'b0, midx_q[1:0] + 2'd1};
            end else if (midx_q == 3'd4) begin
                sreset_d = MDI[0];
            end
`ifdef PC060HA_MIRQ_EN
            else if (midx_q == 3'd5) begin
                mirq_en_d = MDI[0];
            end
`endif
        end else if (m_rd) begin
            if (!MA0) begin
                mdo_d      = '0;
                mdo_d[1:0] = {m2s_full_q, s2m_full_q};
            end else if (!midx_q[2]) begin
                mdo_d   = s2m_q[midx_q[1:0]];
                s2m_clr = (midx_q[1:0] == 2'd3);
                midx_d  = {1'b0, midx_q[1:0] + 2'd1};
            end else begin
                mdo_d = '0;
            end
        end

        // Slave side
        if (SWR) begin
            unique case (SA)
                2'd0: sidx_d = SDI[1:0];
                2'd1: begin
                    s2m_d[sidx_q] = SDI;
                    s2m_set       = (sidx_q == 2'd3);
                    sidx_d        = sidx_q + 2'd1;
                end
                2'd2: nmi_en_d = 1'b0;
                2'd3: nmi_en_d = 1'b1;
            endcase
        end else if (s_rd) begin
            unique case (SA)
                2'd0: begin
                    sdo_d      = '0;
                    sdo_d[1:0] = {s2m_full_q, m2s_full_q};
                end
                2'd1: begin
                    sdo_d   = m2s_q[sidx_q];
                    m2s_clr = (sidx_q == 2'd3);
                    sidx_d  = sidx_q + 2'd1;
                end
                2'd2: begin
                    nmi_en_d = 1'b0;
                    sdo_d    = '0;
                end
                2'd3: begin
                    nmi_en_d = 1'b1;
                    sdo_d    = '0;
                end
            endcase
        end

        // Set wins over a simultaneous clear.
        m2s_full_d = m2s_set | (m2s_full_q & ~m2s_clr);
        s2m_full_d = s2m_set | (s2m_full_q & ~s2m_clr);
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                m2s_q[i] <= '0;
                s2m_q[i] <= '0;
            end
            midx_q     <= '0;
            sidx_q     <= '0;
            m2s_full_q <= 1'b0;
            s2m_full_q <= 1'b0;
            nmi_en_q   <= 1'b0;
            snmi_q     <= 1'b0;
            sreset_q   <= SRESET_INIT;
            mdo_q      <= '0;
            sdo_q      <= '0;
`ifdef PC060HA_MIRQ_EN
            mirq_en_q  <= 1'b0;
            mirq_q     <= 1'b0;
`endif
        end else begin
            m2s_q      <= m2s_d;
            s2m_q      <= s2m_d;
            midx_q     <= midx_d;
            sidx_q     <= sidx_d;
            m2s_full_q <= m2s_full_d;
            s2m_full_q <= s2m_full_d;
            nmi_en_q   <= nmi_en_d;
            snmi_q     <= snmi_d;
            sreset_q   <= sreset_d;
            mdo_q      <= mdo_d;
            sdo_q      <= sdo_d;
`ifdef PC060HA_MIRQ_EN
            mirq_en_q  <= mirq_en_d;
            mirq_q     <= mirq_d;
`endif
        end
    end

    assign MDO    = mdo_q;
    assign SDO    = sdo_q;
    assign SNMI   = snmi_q;
    assign SRESET = sreset_q;
`ifdef PC060HA_MIRQ_EN
    assign MIRQ   = mirq_q;
`endif

endmodule
